vip_flow_fifo_wrapper: RTL and testbench

Parametrised VIP flow-control wrapper that sits between the stream decoder/encoder pair and a streaming algorithm core. It converts decoder ready/valid into the core's stall/read interface. It buffers core output in a first-word-fall-through FIFO, so `stall_out` is registered and tolerates `STALL_MARGIN` cycles of core pipeline latency. It also queues control-packet requests so they are only issued to the encoder once all prior frame data has drained.

---
 rtl/vip_flow_fifo_wrapper.sv | 188 ++++++++++++++++++
 tb/tb_vip_flow_fifo_wrapper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_flow_fifo_wrapper.sv
// vip_flow_fifo_wrapper
// Flow-control shim between the VIP stream decoder/encoder pair and a streaming
// algorithm core.
//   Decoder side : din_valid/din_ready/din_data and decoder status are passed to
//                  the core; the core's read/stall_in interface is derived from them.
//   Core output  : write/data_out/end_of_video_out are buffered in a
//                  first-word-fall-through FIFO. stall_out is registered and
//                  asserts early enough to absorb STALL_MARGIN in-flight writes.
//   Encoder side : dout_valid/dout_ready/dout_data show the FIFO head.
//   Control pkt  : vip_ctrl_send is queued (IDLE/PEND/ISSUE) and forwarded as a
//                  one-cycle encoder_vip_ctrl_send once the FIFO has drained.
//   Status       : fifo_count (occupancy), overflow (sticky dropped-write flag).
module vip_flow_fifo_wrapper #(
  parameter int unsigned BITS_PER_SYMBOL = 8,
  parameter int unsigned SYMBOLS_IN      = 3,
  parameter int unsigned SYMBOLS_OUT     = 1,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned STALL_MARGIN    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  // decoder side
  input  logic                                    din_valid,
  output logic                                    din_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_IN-1:0]   din_data,
  input  logic                                    decoder_is_video,
  input  logic                                    decoder_end_of_video,
  input  logic                                    decoder_vip_ctrl_valid,
  input  logic [15:0]                             decoder_width,
  input  logic [15:0]                             decoder_height,
  input  logic [3:0]                              decoder_interlaced,
  // core input side
  output logic [BITS_PER_SYMBOL*SYMBOLS_IN-1:0]   data_in,
  output logic                                    end_of_video,
  output logic                                    vip_ctrl_valid,
  output logic [15:0]                             width_in,
  output logic [15:0]                             height_in,
  output logic [3:0]                              interlaced_in,
  input  logic                                    read,
  input  logic                                    write,
  output logic                                    stall_in,
  output logic                                    stall_out,
  // core output side
  input  logic [BITS_PER_SYMBOL*SYMBOLS_OUT-1:0]  data_out,
  input  logic                                    end_of_video_out,
  input  logic                                    vip_ctrl_send,
  output logic                                    vip_ctrl_busy,
  input  logic [15:0]                             width_out,
  input  logic [15:0]                             height_out,
  input  logic [3:0]                              interlaced_out,
  // encoder side
  output logic                                    dout_valid,
  input  logic                                    dout_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS_OUT-1:0]  dout_data,
  output logic                                    encoder_end_of_video,
  output logic [15:0]                             encoder_width,
  output logic [15:0]                             encoder_height,
  output logic [3:0]                              encoder_interlaced,
  output logic                                    encoder_vip_ctrl_send,
  input  logic                                    encoder_vip_ctrl_busy,
  // status
  output logic [$clog2(FIFO_DEPTH):0]             fifo_count,
  output logic                                    overflow
);

  localparam int unsigned OW     = BITS_PER_SYMBOL * SYMBOLS_OUT;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned THRESH = FIFO_DEPTH - STALL_MARGIN;

  typedef struct packed {
    logic          eov;
    logic [OW-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  beat_t           mem [FIFO_DEPTH];
  beat_t           head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   next_count;
  logic            full;
  logic            pop;
  logic            push_ok;
  state_t          state;

  // Input side pass-through and core handshake
  assign data_in        = din_data;
  assign end_of_video   = decoder_end_of_video;
  assign vip_ctrl_valid = decoder_vip_ctrl_valid;
  assign width_in       = decoder_width;
  assign height_in      = decoder_height;
  assign interlaced_in  = decoder_interlaced;
  assign din_ready      = ~decoder_is_video | read;
  assign stall_in       = ~(din_valid & decoder_is_video);

  // A write into a full FIFO only lands if the head leaves in the same cycle
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = dout_valid & dout_ready;
  assign push_ok = write & (~full | pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    next_count = count;
    case ({push_ok, pop})
      2'b10:   next_count = count + CW'(1);
      2'b01:   next_count = count - CW'(1);
      default: next_count = count;
    endcase
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{eov: end_of_video_out, data: data_out};
    end
  end

  assign head                 = mem[rd_ptr];
  assign dout_data            = head.data;
  assign encoder_end_of_video = head.eov;
  assign fifo_count           = count;

  // Pointers, occupancy and flow-control flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      stall_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count      <= next_count;
      dout_valid <= (next_count != '0);
      stall_out  <= (next_count >= CW'(THRESH));
      if (write & full & ~pop) overflow <= 1'b1;
    end
  end

  // Control packet sequencer: hold request until frame data has drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      encoder_vip_ctrl_send <= 1'b0;
      encoder_width         <= '0;
      encoder_height        <= '0;
      encoder_interlaced    <= '0;
    end else begin
      case (state)
        IDLE: begin
          encoder_vip_ctrl_send <= 1'b0;
          if (vip_ctrl_send) begin
            encoder_width      <= width_out;
            encoder_height     <= height_out;
            encoder_interlaced <= interlaced_out;
            state              <= PEND;
          end
        end
        PEND: begin
          if ((count == '0) && !encoder_vip_ctrl_busy) begin
            encoder_vip_ctrl_send <= 1'b1;
            state                 <= ISSUE;
          end
        end
        ISSUE: begin
          encoder_vip_ctrl_send <= 1'b0;
          state                 <= IDLE;
        end
        default: begin
          encoder_vip_ctrl_send <= 1'b0;
          state                 <= IDLE;
        end
      endcase
    end
  end

  assign vip_ctrl_busy = (state != IDLE) | encoder_vip_ctrl_busy;

endmodule

// File: tb/tb_vip_flow_fifo_wrapper.sv
// Directed bench for vip_flow_fifo_wrapper (default parameters: depth 8, margin 2).
module tb_vip_flow_fifo_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [23:0] din_data;
  logic        decoder_is_video;
  logic        decoder_end_of_video;
  logic        decoder_vip_ctrl_valid;
  logic [15:0] decoder_width;
  logic [15:0] decoder_height;
  logic [3:0]  decoder_interlaced;
  logic [23:0] data_in;
  logic        end_of_video;
  logic        vip_ctrl_valid;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        read;
  logic        write;
  logic        stall_in;
  logic        stall_out;
  logic [7:0]  data_out;
  logic        end_of_video_out;
  logic        vip_ctrl_send;
  logic        vip_ctrl_busy;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [3:0]  interlaced_out;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  dout_data;
  logic        encoder_end_of_video;
  logic [15:0] encoder_width;
  logic [15:0] encoder_height;
  logic [3:0]  encoder_interlaced;
  logic        encoder_vip_ctrl_send;
  logic        encoder_vip_ctrl_busy;
  logic [3:0]  fifo_count;
  logic        overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] drain_exp [7];

  vip_flow_fifo_wrapper dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .decoder_is_video(decoder_is_video), .decoder_end_of_video(decoder_end_of_video),
    .decoder_vip_ctrl_valid(decoder_vip_ctrl_valid),
    .decoder_width(decoder_width), .decoder_height(decoder_height),
    .decoder_interlaced(decoder_interlaced),
    .data_in(data_in), .end_of_video(end_of_video), .vip_ctrl_valid(vip_ctrl_valid),
    .width_in(width_in), .height_in(height_in), .interlaced_in(interlaced_in),
    .read(read), .write(write), .stall_in(stall_in), .stall_out(stall_out),
    .data_out(data_out), .end_of_video_out(end_of_video_out),
    .vip_ctrl_send(vip_ctrl_send), .vip_ctrl_busy(vip_ctrl_busy),
    .width_out(width_out), .height_out(height_out), .interlaced_out(interlaced_out),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .encoder_end_of_video(encoder_end_of_video),
    .encoder_width(encoder_width), .encoder_height(encoder_height),
    .encoder_interlaced(encoder_interlaced),
    .encoder_vip_ctrl_send(encoder_vip_ctrl_send),
    .encoder_vip_ctrl_busy(encoder_vip_ctrl_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    encoder_vip_ctrl_busy = 1'b1;
    #2;
    vec_cnt++; if (dout_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
    vec_cnt++; if (fifo_count !== 4'd0) begin err_cnt++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    vec_cnt++; if (stall_out !== 1'b0) begin err_cnt++; $display("FAIL reset_stall_out got %b exp 0", stall_out); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL reset_enc_send got %b exp 0", encoder_vip_ctrl_send); end
    vec_cnt++; if (encoder_width !== 16'd0) begin err_cnt++; $display("FAIL reset_enc_width got %0d exp 0", encoder_width); end
    vec_cnt++; if (vip_ctrl_busy !== 1'b1) begin err_cnt++; $display("FAIL reset_busy_follow got %b exp 1", vip_ctrl_busy); end
    encoder_vip_ctrl_busy = 1'b0;
    #1;
    vec_cnt++; if (vip_ctrl_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy_clear got %b exp 0", vip_ctrl_busy); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_input_side();
    din_data = 24'h123456; decoder_width = 16'd1280; decoder_end_of_video = 1'b1;
    decoder_is_video = 1'b0; din_valid = 1'b1; read = 1'b0;
    #1;
    vec_cnt++; if (din_ready !== 1'b1) begin err_cnt++; $display("FAIL nonvideo_din_ready got %b exp 1", din_ready); end
    vec_cnt++; if (stall_in !== 1'b1) begin err_cnt++; $display("FAIL nonvideo_stall_in got %b exp 1", stall_in); end
    vec_cnt++; if (data_in !== 24'h123456) begin err_cnt++; $display("FAIL pass_data_in got %h exp 123456", data_in); end
    vec_cnt++; if (width_in !== 16'd1280) begin err_cnt++; $display("FAIL pass_width_in got %0d exp 1280", width_in); end
    vec_cnt++; if (end_of_video !== 1'b1) begin err_cnt++; $display("FAIL pass_eov got %b exp 1", end_of_video); end
    decoder_is_video = 1'b1;
    #1;
    vec_cnt++; if (din_ready !== 1'b0) begin err_cnt++; $display("FAIL video_noread_din_ready got %b exp 0", din_ready); end
    vec_cnt++; if (stall_in !== 1'b0) begin err_cnt++; $display("FAIL video_valid_stall_in got %b exp 0", stall_in); end
    read = 1'b1;
    #1;
    vec_cnt++; if (din_ready !== 1'b1) begin err_cnt++; $display("FAIL video_read_din_ready got %b exp 1", din_ready); end
    din_valid = 1'b0;
    #1;
    vec_cnt++; if (stall_in !== 1'b1) begin err_cnt++; $display("FAIL video_novalid_stall_in got %b exp 1", stall_in); end
    din_valid = 1'b0; read = 1'b0; decoder_is_video = 1'b0; decoder_end_of_video = 1'b0;
    step();
  endtask

  task automatic test_stream();
    dout_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_out = 8'(i);
      write = 1'b1;
      step();
      vec_cnt++; if (dout_valid !== 1'b1 || dout_data !== 8'(i)) begin err_cnt++; $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", i, dout_valid, dout_data, 8'(i)); end
      vec_cnt++; if (fifo_count !== 4'd1 || stall_out !== 1'b0 || overflow !== 1'b0) begin err_cnt++; $display("FAIL stream_flags%0d got cnt=%0d stall=%b ovf=%b exp 1 0 0", i, fifo_count, stall_out, overflow); end
    end
    write = 1'b0;
    step();
    vec_cnt++; if (dout_valid !== 1'b0 || fifo_count !== 4'd0) begin err_cnt++; $display("FAIL stream_empty got v=%b cnt=%0d exp 0 0", dout_valid, fifo_count); end
    dout_ready = 1'b0;
  endtask

  task automatic test_stall_overflow();
    dout_ready = 1'b0;
    // Core writes until it sees stall_out, then one more in-flight beat
    for (int i = 1; i <= 7; i++) begin
      data_out = 8'(8'hA0 + i);
      write = 1'b1;
      step();
      vec_cnt++; if (fifo_count !== 4'(i)) begin err_cnt++; $display("FAIL fill_count%0d got %0d exp %0d", i, fifo_count, i); end
      vec_cnt++; if (stall_out !== (i >= 6)) begin err_cnt++; $display("FAIL fill_stall%0d got %b exp %b", i, stall_out, (i >= 6)); end
    end
    vec_cnt++; if (overflow !== 1'b0 || dout_data !== 8'hA1) begin err_cnt++; $display("FAIL fill_end got ovf=%b head=%h exp 0 a1", overflow, dout_data); end
    data_out = 8'hA8;
    step();
    vec_cnt++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin err_cnt++; $display("FAIL full_count got cnt=%0d ovf=%b exp 8 0", fifo_count, overflow); end
    data_out = 8'hDD;
    step();
    vec_cnt++; if (fifo_count !== 4'd8 || overflow !== 1'b1 || dout_data !== 8'hA1) begin err_cnt++; $display("FAIL drop_write got cnt=%0d ovf=%b head=%h exp 8 1 a1", fifo_count, overflow, dout_data); end
    write = 1'b0;
    step();
    vec_cnt++; if (overflow !== 1'b1 || dout_data !== 8'hA1 || dout_valid !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got ovf=%b head=%h v=%b exp 1 a1 1", overflow, dout_data, dout_valid); end
    data_out = 8'hEE; write = 1'b1; dout_ready = 1'b1;
    step();
    vec_cnt++; if (fifo_count !== 4'd8 || dout_data !== 8'hA2 || overflow !== 1'b1) begin err_cnt++; $display("FAIL full_push_pop got cnt=%0d head=%h ovf=%b exp 8 a2 1", fifo_count, dout_data, overflow); end
    write = 1'b0;
    drain_exp = '{8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hEE};
    for (int j = 0; j < 7; j++) begin
      step();
      vec_cnt++; if (dout_data !== drain_exp[j] || fifo_count !== 4'(7 - j)) begin err_cnt++; $display("FAIL drain%0d got head=%h cnt=%0d exp %h %0d", j, dout_data, fifo_count, drain_exp[j], 7 - j); end
    end
    step();
    vec_cnt++; if (dout_valid !== 1'b0 || stall_out !== 1'b0 || overflow !== 1'b1) begin err_cnt++; $display("FAIL drained got v=%b stall=%b ovf=%b exp 0 0 1", dout_valid, stall_out, overflow); end
    dout_ready = 1'b0;
    rst = 1'b0;
    #1;
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_reset got %b exp 0", overflow); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_ctrl_packet();
    dout_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      data_out = 8'(8'h11 * i);
      write = 1'b1;
      step();
    end
    write = 1'b0;
    vip_ctrl_send = 1'b1; width_out = 16'd640; height_out = 16'd480; interlaced_out = 4'd0;
    step();
    vec_cnt++; if (vip_ctrl_busy !== 1'b1 || encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL ctrl_pend got busy=%b send=%b exp 1 0", vip_ctrl_busy, encoder_vip_ctrl_send); end
    vec_cnt++; if (encoder_width !== 16'd640 || encoder_height !== 16'd480 || fifo_count !== 4'd3) begin err_cnt++; $display("FAIL ctrl_latch got w=%0d h=%0d cnt=%0d exp 640 480 3", encoder_width, encoder_height, fifo_count); end
    width_out = 16'd1920; height_out = 16'd1080; interlaced_out = 4'd3;
    step();
    vec_cnt++; if (encoder_width !== 16'd640 || encoder_interlaced !== 4'd0 || encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL ctrl_ignore got w=%0d i=%0d send=%b exp 640 0 0", encoder_width, encoder_interlaced, encoder_vip_ctrl_send); end
    vip_ctrl_send = 1'b0;
    dout_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      vec_cnt++; if (encoder_vip_ctrl_send !== 1'b0 || fifo_count !== 4'(3 - k)) begin err_cnt++; $display("FAIL ctrl_wait%0d got send=%b cnt=%0d exp 0 %0d", k, encoder_vip_ctrl_send, fifo_count, 3 - k); end
    end
    step();
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b1 || encoder_width !== 16'd640 || encoder_height !== 16'd480) begin err_cnt++; $display("FAIL ctrl_issue got send=%b w=%0d h=%0d exp 1 640 480", encoder_vip_ctrl_send, encoder_width, encoder_height); end
    step();
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b0 || vip_ctrl_busy !== 1'b0) begin err_cnt++; $display("FAIL ctrl_done got send=%b busy=%b exp 0 0", encoder_vip_ctrl_send, vip_ctrl_busy); end
    // Empty FIFO, idle encoder: two-cycle request latency
    vip_ctrl_send = 1'b1; width_out = 16'd100; height_out = 16'd50;
    step();
    vip_ctrl_send = 1'b0;
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL ctrl_lat1 got %b exp 0", encoder_vip_ctrl_send); end
    step();
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b1 || encoder_width !== 16'd100) begin err_cnt++; $display("FAIL ctrl_lat2 got send=%b w=%0d exp 1 100", encoder_vip_ctrl_send, encoder_width); end
    step();
    // Busy encoder holds the request in PEND
    vip_ctrl_send = 1'b1; width_out = 16'd200;
    step();
    vip_ctrl_send = 1'b0; encoder_vip_ctrl_busy = 1'b1;
    step();
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b0 || vip_ctrl_busy !== 1'b1) begin err_cnt++; $display("FAIL ctrl_enc_busy got send=%b busy=%b exp 0 1", encoder_vip_ctrl_send, vip_ctrl_busy); end
    encoder_vip_ctrl_busy = 1'b0;
    step();
    vec_cnt++; if (encoder_vip_ctrl_send !== 1'b1 || encoder_width !== 16'd200) begin err_cnt++; $display("FAIL ctrl_enc_release got send=%b w=%0d exp 1 200", encoder_vip_ctrl_send, encoder_width); end
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      data_out = 8'(8'h50 + i);
      write = 1'b1;
      step();
    end
    write = 1'b0;
    vip_ctrl_send = 1'b1; width_out = 16'd320; height_out = 16'd240; interlaced_out = 4'd5;
    step();
    vip_ctrl_send = 1'b0;
    vec_cnt++; if (vip_ctrl_busy !== 1'b1 || fifo_count !== 4'd5) begin err_cnt++; $display("FAIL mid_pre got busy=%b cnt=%0d exp 1 5", vip_ctrl_busy, fifo_count); end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++; if (dout_valid !== 1'b0 || fifo_count !== 4'd0 || stall_out !== 1'b0) begin err_cnt++; $display("FAIL mid_fifo got v=%b cnt=%0d stall=%b exp 0 0 0", dout_valid, fifo_count, stall_out); end
    vec_cnt++; if (encoder_width !== 16'd0 || encoder_height !== 16'd0 || encoder_interlaced !== 4'd0) begin err_cnt++; $display("FAIL mid_fields got w=%0d h=%0d i=%0d exp 0 0 0", encoder_width, encoder_height, encoder_interlaced); end
    vec_cnt++; if (vip_ctrl_busy !== 1'b0 || encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL mid_ctrl got busy=%b send=%b exp 0 0", vip_ctrl_busy, encoder_vip_ctrl_send); end
    @(negedge clk);
    rst = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vec_cnt++; if (dout_valid !== 1'b0 || encoder_vip_ctrl_send !== 1'b0) begin err_cnt++; $display("FAIL mid_after%0d got v=%b send=%b exp 0 0", c, dout_valid, encoder_vip_ctrl_send); end
    end
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0; din_data = '0; decoder_is_video = 1'b0;
    decoder_end_of_video = 1'b0; decoder_vip_ctrl_valid = 1'b0;
    decoder_width = '0; decoder_height = '0; decoder_interlaced = '0;
    read = 1'b0; write = 1'b0; data_out = '0; end_of_video_out = 1'b0;
    vip_ctrl_send = 1'b0; width_out = '0; height_out = '0; interlaced_out = '0;
    dout_ready = 1'b0; encoder_vip_ctrl_busy = 1'b0;
    #1;
    test_reset();
    test_input_side();
    test_stream();
    test_stall_overflow();
    test_ctrl_packet();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1);
  end

endmodule
